inst_queue: RTL and testbench
=============================

# inst_queue

Parametrised instruction queue between the fetch stage and the decode stage. It replaces the single-entry fetch/decode pipeline register with a DEPTH-entry circular FIFO carrying {pc, inst, predicted-taken}. It decouples fetch from decode stalls and supports a same-cycle flush on branch/jump redirect. The queue is gated by the global `rdy` enable.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the pc field
- `INST_WIDTH`, 32, width of the instruction field
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `PTR_W`, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  reset; synchronous, active-high; overrides `rdy`
- `rdy`  in  1  global enable; when low, all state holds
- `flush_i`  in  1  redirect; discard all queued entries
- `enq_valid_i`  in  1  fetch presents an entry
- `enq_pc_i`  in  ADDR_WIDTH  pc of the entry
- `enq_inst_i`  in  INST_WIDTH  instruction word
- `enq_pred_i`  in  1  predicted-taken flag from fetch
- `enq_ready_o`  out  1  queue can accept an entry this cycle
- `deq_valid_o`  out  1  head entry is valid
- `deq_pc_o`  out  ADDR_WIDTH  head pc
- `deq_inst_o`  out  INST_WIDTH  head instruction
- `deq_pred_o`  out  1  head predicted-taken flag
- `deq_ready_i`  in  1  decode accepts the head entry
- `count_o`  out  PTR_W+1  number of valid entries, 0..DEPTH

## Operation
- Storage: DEPTH × (ADDR_WIDTH+INST_WIDTH+1) register array; head and tail pointers of PTR_W bits, wrapping modulo DEPTH; count register of PTR_W+1 bits.
- `enq_ready_o` = (count != DEPTH) & ~flush_i.
- `deq_valid_o` = (count != 0) & ~flush_i.
- `deq_*` data are driven directly from entry[head]. No bypass from enq to deq.
- enq_fire = rdy & enq_valid_i & enq_ready_o: write entry[tail], then tail+1.
- deq_fire = rdy & deq_valid_o & deq_ready_i: head+1.
- Count update: enq_fire only → +1; deq_fire only → −1; both or neither → unchanged. Simultaneous enq and deq is legal at any count 1..DEPTH−1.
- Full (count = DEPTH): enq_ready_o low, so enq is never accepted, even if a deq fires in the same cycle.
- Empty: deq_valid_o low; deq data equal stale entry[head] and are don't-care.
- Flush (rdy & flush_i): highest priority. head, tail and count become 0 next cycle. Any enq or deq in that cycle is suppressed, because the outputs are masked by ~flush_i. Entry contents are not cleared.
- rdy low: no pointer, count or storage change, and flush_i is ignored. Outputs still reflect the held state.
- Reset: head = tail = count = 0 and all entries are cleared to zero. This holds regardless of rdy and may occur mid-operation; in-flight entries are lost.

## Timing
- Reset values: enq_ready_o = 1 (if flush_i = 0), deq_valid_o = 0, deq_pc_o = 0, deq_inst_o = 0, deq_pred_o = 0, count_o = 0.
- Latency: an entry enqueued at edge N is visible on deq_* with deq_valid_o = 1 after edge N (cycle N+1), when the queue was empty.
- Throughput: one enq and one deq per cycle, sustained.
- enq_ready_o and deq_valid_o depend combinationally only on registered count and flush_i. There is no path from deq_ready_i to enq_ready_o, and none from enq_valid_i to deq_valid_o.
- Flush asserted at cycle N: from cycle N+1, count_o = 0, deq_valid_o = 0 and enq_ready_o = 1. The first post-flush enq can happen in cycle N+1.
- Handshake rule: producer holds enq_* stable while enq_valid_i & ~enq_ready_o. Decode samples deq_* only when deq_valid_o & deq_ready_i.

## Test plan
- Reset then fill (DEPTH = 4): enq pc 0x0, 0x4, 0x8, 0xC with deq_ready_i = 0 → count_o = 4, enq_ready_o = 0. A 5th enq (pc 0x10) is not accepted. Drain → pc out order 0x0, 0x4, 0x8, 0xC, then deq_valid_o = 0.
- Simultaneous enq/deq: at count 2, enq and deq each cycle for 10 cycles (pc +4 per enq) → count_o stays 2, pcs emerge in order, and pointers wrap past DEPTH twice with no loss.
- Full with deq: at count 4, assert deq_ready_i and enq_valid_i together → one entry leaves, enq rejected, count_o = 3; next cycle enq accepted.
- Flush: at count 3, assert flush_i with enq_valid_i and deq_ready_i high → deq_valid_o and enq_ready_o low that cycle. Next cycle count_o = 0; a new enq pc 0x100 then appears at deq_pc_o one cycle later.
- rdy low: at count 2, drop rdy for 3 cycles while toggling enq/deq/flush → count_o, head data and pointers are unchanged, and operation resumes correctly when rdy returns high.
- Reset mid-operation: at count 3, assert rst with rdy = 0 → next cycle count_o = 0, deq_valid_o = 0, deq_pc_o = 0, deq_inst_o = 0.

Source files
------------

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue (circular FIFO of {pc, inst, pred})
//
// Ports:
//   clk, rst          clock and synchronous active-high reset (reset wins over rdy)
//   rdy               global enable; low freezes all state
//   flush_i           redirect; empties the queue next cycle
//   enq_*             fetch side: valid/pc/inst/pred in, ready out
//   deq_*             decode side: valid/pc/inst/pred out, ready in
//   count_o           number of valid entries, 0..DEPTH

module inst_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush_i,
    input  logic                  enq_valid_i,
    input  logic [ADDR_WIDTH-1:0] enq_pc_i,
    input  logic [INST_WIDTH-1:0] enq_inst_i,
    input  logic                  enq_pred_i,
    output logic                  enq_ready_o,
    output logic                  deq_valid_o,
    output logic [ADDR_WIDTH-1:0] deq_pc_o,
    output logic [INST_WIDTH-1:0] deq_inst_o,
    output logic                  deq_pred_o,
    input  logic                  deq_ready_i,
    output logic [PTR_W:0]        count_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic                  pred_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic enq_fire;
    logic deq_fire;

    // Handshake outputs look only at registered count and flush, so there is
    // no combinational path between the two sides of the queue.
    assign enq_ready_o = (count != FULL_COUNT) & ~flush_i;
    assign deq_valid_o = (count != '0) & ~flush_i;

    assign deq_pc_o   = pc_mem[head];
    assign deq_inst_o = inst_mem[head];
    assign deq_pred_o = pred_mem[head];
    assign count_o    = count;

    assign enq_fire = rdy & enq_valid_i & enq_ready_o;
    assign deq_fire = rdy & deq_valid_o & deq_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                pred_mem[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (flush_i) begin
                // Entry contents are left in place; only the bookkeeping resets.
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq_fire) begin
                    pc_mem[tail]   <= enq_pc_i;
                    inst_mem[tail] <= enq_inst_i;
                    pred_mem[tail] <= enq_pred_i;
                    tail           <= tail + 1'b1;
                end
                if (deq_fire) begin
                    head <= head + 1'b1;
                end
                case ({enq_fire, deq_fire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue

module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush_i;
    logic        enq_valid_i;
    logic [31:0] enq_pc_i;
    logic [31:0] enq_inst_i;
    logic        enq_pred_i;
    logic        enq_ready_o;
    logic        deq_valid_o;
    logic [31:0] deq_pc_o;
    logic [31:0] deq_inst_o;
    logic        deq_pred_o;
    logic        deq_ready_i;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_errors = 0;

    inst_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_pc_i    (enq_pc_i),
        .enq_inst_i  (enq_inst_i),
        .enq_pred_i  (enq_pred_i),
        .enq_ready_o (enq_ready_o),
        .deq_valid_o (deq_valid_o),
        .deq_pc_o    (deq_pc_o),
        .deq_inst_o  (deq_inst_o),
        .deq_pred_o  (deq_pred_o),
        .deq_ready_i (deq_ready_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic v, input logic [31:0] pc);
        enq_valid_i = v;
        enq_pc_i    = pc;
        enq_inst_i  = inst_of(pc);
        enq_pred_i  = pc[2];
    endtask

    task automatic push(input logic [31:0] pc);
        set_enq(1'b1, pc);
        deq_ready_i = 1'b0;
        step();
        enq_valid_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc);
        #1;
        check({tag, "_valid"}, 64'(deq_valid_o), 64'd1);
        check({tag, "_pc"},    64'(deq_pc_o),    64'(pc));
        check({tag, "_inst"},  64'(deq_inst_o),  64'(inst_of(pc)));
        check({tag, "_pred"},  64'(deq_pred_o),  64'(pc[2]));
        deq_ready_i = 1'b1;
        step();
        deq_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush_i = 1'b0; deq_ready_i = 1'b0;
        set_enq(1'b0, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_count",     64'(count_o),     64'd0);
        check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
        check("rst_deq_valid", 64'(deq_valid_o), 64'd0);
        check("rst_deq_pc",    64'(deq_pc_o),    64'd0);
        check("rst_deq_inst",  64'(deq_inst_o),  64'd0);
        check("rst_deq_pred",  64'(deq_pred_o),  64'd0);

        // Fill to full, reject a fifth entry, drain in order.
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        check("fill_count",     64'(count_o),     64'd4);
        check("fill_enq_ready", 64'(enq_ready_o), 64'd0);
        push(32'h10);
        check("fill_reject_count", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) pop_check("drain", 32'(i * 4));
        check("drain_deq_valid", 64'(deq_valid_o), 64'd0);
        check("drain_count",     64'(count_o),     64'd0);

        // Simultaneous enq/deq at count 2; pointers wrap several times.
        push(32'h200);
        push(32'h204);
        for (int k = 0; k < 10; k++) begin
            set_enq(1'b1, 32'h208 + 32'(4 * k));
            deq_ready_i = 1'b1;
            #1;
            check("sim_deq_pc", 64'(deq_pc_o), 64'(32'h200 + 32'(4 * k)));
            step();
            check("sim_count", 64'(count_o), 64'd2);
        end
        enq_valid_i = 1'b0; deq_ready_i = 1'b0;
        pop_check("sim_tail0", 32'h228);
        pop_check("sim_tail1", 32'h22C);
        check("sim_empty", 64'(deq_valid_o), 64'd0);

        // Full with deq: enq rejected that cycle, accepted the next.
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i));
        set_enq(1'b1, 32'h310);
        deq_ready_i = 1'b1;
        #1;
        check("full_enq_ready", 64'(enq_ready_o), 64'd0);
        check("full_deq_pc",    64'(deq_pc_o),    64'h300);
        step();
        deq_ready_i = 1'b0;
        check("full_count_after", 64'(count_o), 64'd3);
        check("full_enq_ready2",  64'(enq_ready_o), 64'd1);
        step();
        enq_valid_i = 1'b0;
        check("full_count_refill", 64'(count_o), 64'd4);
        for (int i = 1; i < 5; i++) pop_check("full_drain", 32'h300 + 32'(4 * i));

        // Flush with enq and deq both requested.
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(4 * i));
        set_enq(1'b1, 32'h40C);
        deq_ready_i = 1'b1;
        flush_i = 1'b1;
        #1;
        check("flush_deq_valid", 64'(deq_valid_o), 64'd0);
        check("flush_enq_ready", 64'(enq_ready_o), 64'd0);
        step();
        flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
        #1;
        check("flush_count",      64'(count_o),     64'd0);
        check("flush_deq_valid2", 64'(deq_valid_o), 64'd0);
        check("flush_enq_ready2", 64'(enq_ready_o), 64'd1);
        push(32'h100);
        check("flush_new_count", 64'(count_o), 64'd1);
        pop_check("flush_new", 32'h100);
        check("flush_new_empty", 64'(count_o), 64'd0);

        // rdy low freezes everything, including flush.
        push(32'h500);
        push(32'h504);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_enq(c != 2, 32'h508);
            deq_ready_i = 1'b1;
            flush_i = (c == 1);
            step();
            check("rdy_count", 64'(count_o),  64'd2);
            check("rdy_head",  64'(deq_pc_o), 64'h500);
        end
        rdy = 1'b1; flush_i = 1'b0; deq_ready_i = 1'b0; enq_valid_i = 1'b0;
        push(32'h50C);
        check("rdy_resume_count", 64'(count_o), 64'd3);
        pop_check("rdy_drain0", 32'h500);
        pop_check("rdy_drain1", 32'h504);
        pop_check("rdy_drain2", 32'h50C);
        check("rdy_empty", 64'(deq_valid_o), 64'd0);

        // Reset mid-operation with rdy low.
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i));
        rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; rdy = 1'b1;
        #1;
        check("mrst_count",     64'(count_o),     64'd0);
        check("mrst_deq_valid", 64'(deq_valid_o), 64'd0);
        check("mrst_deq_pc",    64'(deq_pc_o),    64'd0);
        check("mrst_deq_inst",  64'(deq_inst_o),  64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
